// File: rtl/matrix_ops_pkg.sv
// Shared types for the matrix accelerator front end: op encoding, scheduler states and queue entries.
package matrix_ops_pkg;

    typedef enum logic [1:0] {
        MX_OP_MUL       = 2'd0,
        MX_OP_MAC       = 2'd1,
        MX_OP_ADD       = 2'd2,
        MX_OP_TRANSPOSE = 2'd3
    } matrix_op_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_START,
        SCHED_BUSY,
        SCHED_WB
    } sched_state_t;

    typedef struct packed {
        matrix_op_t op;
        logic [4:0] rd;
    } sched_entry_t;

endpackage

// File: rtl/matrix_op_queue.sv
// In-order pending-op FIFO with flush, occupancy count and a flat per-slot valid/rd view
// used by the hazard compare.
module matrix_op_queue
    import matrix_ops_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  matrix_op_t              push_op,
    input  logic [ADDR_W-1:0]       push_rd,
    input  logic                    pop,
    output matrix_op_t              head_op,
    output logic [ADDR_W-1:0]       head_rd,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        count,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH*ADDR_W-1:0] entry_rd
);

    matrix_op_t        op_mem [DEPTH];
    logic [ADDR_W-1:0] rd_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; slot validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            op_mem[wr_ptr_q] <= push_op;
            rd_mem[wr_ptr_q] <= push_rd;
        end
    end

    assign head_op = op_mem[rd_ptr_q];
    assign head_rd = rd_mem[rd_ptr_q];
    assign count   = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [PTR_W-1:0] offset;
        assign offset                        = PTR_W'(g) - rd_ptr_q;
        assign entry_valid[g]                = ({1'b0, offset} < count_q);
        assign entry_rd[g*ADDR_W +: ADDR_W]  = rd_mem[g];
    end

endmodule

// File: rtl/matrix_issue_scheduler.sv
// Issue scheduler for the shared matrix accelerator: queues decoded ops, issues one at a time,
// holds the result for writeback and flags RAW hazards against pending destinations.
module matrix_issue_scheduler
    import matrix_ops_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  matrix_op_t                   req_op,
    input  logic [REG_ADDR_W-1:0]        req_rd,
    input  logic                         flush,
    output logic                         mx_start,
    output matrix_op_t                   mx_op,
    output logic [REG_ADDR_W-1:0]        mx_rd,
    input  logic                         mx_busy,
    input  logic                         mx_done,
    output logic                         wb_valid,
    output logic [REG_ADDR_W-1:0]        wb_rd,
    input  logic                         wb_ready,
    input  logic [REG_ADDR_W-1:0]        chk_rs1,
    input  logic [REG_ADDR_W-1:0]        chk_rs2,
    output logic                         chk_hazard,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         sched_busy
);

    logic                              q_full, q_empty, issue;
    matrix_op_t                        head_op;
    logic [REG_ADDR_W-1:0]             head_rd;
    logic [QUEUE_DEPTH-1:0]            entry_valid;
    logic [QUEUE_DEPTH*REG_ADDR_W-1:0] entry_rd;

    sched_state_t          state_q;
    logic                  mx_start_q, wb_valid_q;
    matrix_op_t            mx_op_q;
    logic [REG_ADDR_W-1:0] mx_rd_q;

    assign req_ready = !q_full && !flush;
    // Issue is held off during a flush so the popped op cannot escape the discard.
    assign issue     = (state_q == SCHED_IDLE) && !q_empty && !mx_busy && !flush;

    matrix_op_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .ADDR_W (REG_ADDR_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (req_valid && req_ready),
        .push_op     (req_op),
        .push_rd     (req_rd),
        .pop         (issue),
        .head_op     (head_op),
        .head_rd     (head_rd),
        .full        (q_full),
        .empty       (q_empty),
        .count       (queue_count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCHED_IDLE;
            mx_start_q <= 1'b0;
            wb_valid_q <= 1'b0;
            mx_op_q    <= MX_OP_MUL;
            mx_rd_q    <= '0;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    if (issue) begin
                        mx_op_q    <= head_op;
                        mx_rd_q    <= head_rd;
                        mx_start_q <= 1'b1;
                        state_q    <= SCHED_START;
                    end
                end
                SCHED_START: begin
                    mx_start_q <= 1'b0;
                    state_q    <= SCHED_BUSY;
                end
                SCHED_BUSY: begin
                    if (mx_done) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= SCHED_WB;
                    end
                end
                SCHED_WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= SCHED_IDLE;
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    assign mx_start   = mx_start_q;
    assign mx_op      = mx_op_q;
    assign mx_rd      = mx_rd_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = mx_rd_q;
    assign sched_busy = (state_q != SCHED_IDLE) || !q_empty;

    function automatic logic src_match(input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] rs1,
                                       input logic [REG_ADDR_W-1:0] rs2);
        return ((rs1 != '0) && (rs1 == rd)) || ((rs2 != '0) && (rs2 == rd));
    endfunction

    logic [QUEUE_DEPTH:0] hit;

    for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_hit
        assign hit[g] = entry_valid[g] &&
                        src_match(entry_rd[g*REG_ADDR_W +: REG_ADDR_W], chk_rs1, chk_rs2);
    end
    assign hit[QUEUE_DEPTH] = (state_q != SCHED_IDLE) && src_match(mx_rd_q, chk_rs1, chk_rs2);
    assign chk_hazard       = |hit;

endmodule

// File: tb/tb_matrix_issue_scheduler.sv
// Directed bench for matrix_issue_scheduler: a per-cycle vector table plus hand sequences for
// backpressure, flush, writeback stall and reset mid-operation.
module tb_matrix_issue_scheduler;
    import matrix_ops_pkg::*;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, flush, mx_start, mx_busy, mx_done;
    logic       wb_valid, wb_ready, chk_hazard, sched_busy;
    matrix_op_t req_op, mx_op;
    logic [4:0] req_rd, mx_rd, wb_rd, chk_rs1, chk_rs2;
    logic [2:0] queue_count;

    always #5 clk = ~clk;

    matrix_issue_scheduler #(
        .QUEUE_DEPTH (4),
        .REG_ADDR_W  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .flush       (flush),
        .mx_start    (mx_start),
        .mx_op       (mx_op),
        .mx_rd       (mx_rd),
        .mx_busy     (mx_busy),
        .mx_done     (mx_done),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_ready    (wb_ready),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_hazard  (chk_hazard),
        .queue_count (queue_count),
        .sched_busy  (sched_busy)
    );

    typedef struct packed {
        logic       req_v;
        logic [1:0] op;
        logic [4:0] rd;
        logic       fl, busy, done, wbr;
        logic [4:0] rs1, rs2;
        logic       e_rdy, e_st;
        logic [1:0] e_op;
        logic [4:0] e_mrd;
        logic       e_wbv;
        logic [4:0] e_wrd;
        logic       e_hz;
        logic [2:0] e_qc;
    } vec_t;

    vec_t vecs [18];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_op = MX_OP_MUL; req_rd = '0; flush = 1'b0;
        mx_busy = 1'b0; mx_done = 1'b0; wb_ready = 1'b0; chk_rs1 = '0; chk_rs2 = '0;
    endtask

    // Entered and left at negedge+1.
    task automatic do_reset(input string name);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(name, {req_ready, mx_start, mx_op, mx_rd, wb_valid, wb_rd, chk_hazard,
                     queue_count, sched_busy}, {1'b1, 19'b0});
    endtask

    task automatic wait_start(input string name, input logic [4:0] exp_rd);
        int n = 0;
        while (mx_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, " start"}, mx_start, 1);
        check({name, " rd"}, mx_rd, exp_rd);
    endtask

    task automatic run_one(input string name, input logic [4:0] exp_rd);
        wait_start(name, exp_rd);
        @(negedge clk);
        mx_done = 1'b1;
        @(negedge clk);
        mx_done  = 1'b0;
        wb_ready = 1'b1;
        #1;
        check({name, " wb"}, {wb_valid, wb_rd}, {1'b1, exp_rd});
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        check({name, " wb drop"}, wb_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // req_v op rd fl busy done wbr rs1 rs2 | rdy st op mrd wbv wrd hz qc
        vecs[0]  = '{1, 1, 7, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 0, 0, 0, 0, 0, 1, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 7,  1, 1, 1, 7, 0, 7, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 7, 0, 7, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 7, 0, 7, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 0, 1, 7, 1, 7, 1, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 7, 1, 7, 0, 0};
        vecs[7]  = '{1, 2, 3, 0, 0, 0, 0, 7, 0,  1, 0, 1, 7, 0, 7, 0, 0};
        vecs[8]  = '{1, 3, 9, 0, 1, 0, 0, 3, 0,  1, 0, 1, 7, 0, 7, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 0, 9, 0,  1, 0, 1, 7, 0, 7, 1, 2};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 4,  1, 0, 1, 7, 0, 7, 0, 2};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 9,  1, 0, 1, 7, 0, 7, 1, 2};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 0, 1, 7, 0, 7, 1, 2};
        vecs[13] = '{0, 0, 0, 0, 1, 0, 0, 3, 0,  1, 1, 2, 3, 0, 3, 1, 1};
        vecs[14] = '{0, 0, 0, 0, 1, 1, 0, 3, 0,  1, 0, 2, 3, 0, 3, 1, 1};
        vecs[15] = '{0, 0, 0, 0, 1, 0, 1, 3, 0,  1, 0, 2, 3, 1, 3, 1, 1};
        vecs[16] = '{1, 0, 0, 0, 1, 0, 0, 3, 0,  1, 0, 2, 3, 0, 3, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 2, 3, 0, 3, 0, 2};

        do_reset("reset state");

        // Single op, done-in-START ignored, writeback handshake, hazard window
        for (int k = 0; k < 18; k++) begin
            req_valid = vecs[k].req_v;
            req_op    = matrix_op_t'(vecs[k].op);
            req_rd    = vecs[k].rd;
            flush     = vecs[k].fl;
            mx_busy   = vecs[k].busy;
            mx_done   = vecs[k].done;
            wb_ready  = vecs[k].wbr;
            chk_rs1   = vecs[k].rs1;
            chk_rs2   = vecs[k].rs2;
            #1;
            check($sformatf("vec%0d", k),
                  {req_ready, mx_start, mx_op, mx_rd, wb_valid, wb_rd, chk_hazard, queue_count},
                  {vecs[k].e_rdy, vecs[k].e_st, vecs[k].e_op, vecs[k].e_mrd, vecs[k].e_wbv,
                   vecs[k].e_wrd, vecs[k].e_hz, vecs[k].e_qc});
            @(negedge clk);
        end

        // Fill and backpressure, then drain in order
        do_reset("reset before fill");
        mx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_rd    = 5'(10 + i);
            req_op    = matrix_op_t'(i % 4);
            #1;
            check($sformatf("fill ready %0d", i), req_ready, (i < 4));
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1;
        check("fill count", queue_count, 4);
        check("fill ready held low", req_ready, 0);
        mx_busy = 1'b0;
        for (int i = 0; i < 4; i++) run_one($sformatf("drain%0d", i), 5'(10 + i));
        check("drain empty", {queue_count, sched_busy}, 0);

        // Flush with one op in flight and a same-cycle push
        do_reset("reset before flush");
        req_valid = 1'b1; req_op = MX_OP_TRANSPOSE; req_rd = 5;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        wait_start("flush issue", 5);
        mx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_rd    = 5'(20 + i);
        end
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_rd = 23;
        #1;
        check("flush pre count", queue_count, 3);
        check("flush ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; chk_rs1 = 20;
        #1;
        check("flush count", queue_count, 0);
        check("flush hazard dropped", chk_hazard, 0);
        chk_rs1 = 23;
        #1;
        check("flush push dropped", chk_hazard, 0);
        chk_rs1 = 5;
        #1;
        check("flush inflight hazard", chk_hazard, 1);
        chk_rs1 = 0; mx_done = 1'b1;
        @(negedge clk);
        mx_done = 1'b0;
        #1;
        check("flush wb", {wb_valid, wb_rd}, {1'b1, 5'd5});
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0; mx_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("flush no ghost issue", {mx_start, wb_valid, sched_busy}, 0);

        // Writeback stall holds the result and blocks the next issue
        do_reset("reset before stall");
        req_valid = 1'b1; req_op = MX_OP_MAC; req_rd = 6;
        @(negedge clk);
        req_op = MX_OP_ADD; req_rd = 8;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("stall first issue", {mx_start, mx_op, mx_rd, queue_count},
              {1'b1, MX_OP_MAC, 5'd6, 3'd1});
        @(negedge clk);
        mx_done = 1'b1;
        @(negedge clk);
        mx_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("stall hold %0d", i), {wb_valid, wb_rd, mx_start, queue_count},
                  {1'b1, 5'd6, 1'b0, 3'd1});
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        check("stall release wb", wb_valid, 1);
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        check("stall gap", {mx_start, wb_valid}, 0);
        @(negedge clk);
        #1;
        check("stall next issue", {mx_start, mx_op, mx_rd}, {1'b1, MX_OP_ADD, 5'd8});

        // Reset mid-BUSY abandons the op; a late done must not produce writeback
        mx_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_rd = 12;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("pre reset state", {queue_count, sched_busy}, {3'd1, 1'b1});
        do_reset("reset mid busy");
        mx_done = 1'b1;
        @(negedge clk);
        mx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("post reset quiet %0d", i), {wb_valid, mx_start, sched_busy}, 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
